// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and transmit FSM state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS      = 8;
  localparam int unsigned UART_STOP_BITS      = 1;
  localparam int unsigned UART_CLOCKS_PER_BIT = 5000;
  localparam int unsigned UART_IDX_W          = $clog2(UART_DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: strobes bit_end on the last clock of each bit.
// Held at zero while restart is high, so each frame starts phase-aligned.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic bit_end
);

  localparam int unsigned CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt;

  // Strobe on the final count of the bit.
  assign bit_end = enable && !restart && (cnt == CNT_W'(CLOCKS_PER_BIT - 1));

  // Count only while enabled; wrap at the bit end.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= bit_end ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for a single 8N1 serial transmitter.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = UART_CLOCKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id
);

  uart_tx_state_e               state, state_n;
  logic [UART_DATA_BITS-1:0]    shift_q, shift_n;
  logic [UART_IDX_W-1:0]        idx_q, idx_n;
  logic                         last_q, last_n;
  logic                         grant_q, grant_n;
  logic                         tx_q, tx_n;
  logic                         busy_q;
  logic                         gnt_sel;
  logic                         in_idle;
  logic                         xfer;
  logic                         bit_end;

  // Round-robin pick: both valid goes to the one not served last.
  assign gnt_sel = (req0_valid && req1_valid) ? !last_q : req1_valid;
  assign in_idle = (state == IDLE) && !reset;

  // Ready only in IDLE, only to the granted requester that is asking.
  assign req0_ready = in_idle && req0_valid && !gnt_sel;
  assign req1_ready = in_idle && req1_valid && gnt_sel;
  assign xfer       = req0_ready || req1_ready;

  uart_bit_timer #(
    .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (state == IDLE),
    .enable  (state != IDLE),
    .bit_end (bit_end)
  );

  // Next-state, shift register, arbitration bookkeeping and next line level.
  always_comb begin
    state_n = state;
    shift_n = shift_q;
    idx_n   = idx_q;
    last_n  = last_q;
    grant_n = grant_q;
    tx_n    = 1'b1;

    unique case (state)
      IDLE: begin
        if (xfer) begin
          shift_n = gnt_sel ? req1_data : req0_data;
          grant_n = gnt_sel;
          last_n  = gnt_sel;
          idx_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift_q >> 1;
          if (idx_q == UART_IDX_W'(UART_DATA_BITS - 1)) begin
            state_n = STOP;
          end else begin
            idx_n = idx_q + UART_IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level follows the state being entered so tx lines up with it.
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      shift_q <= shift_n;
      idx_q   <= idx_n;
      last_q  <= last_n;
      grant_q <= grant_n;
      tx_q    <= tx_n;
      busy_q  <= (state_n != IDLE);
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule
